// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the trap/interrupt sequencer.
//   - mcause codes for the three machine interrupts
//   - bit positions of the interrupt lines inside mie/mip style vectors
//   - sequencer state encoding and arbitration result encoding
//   - irq_cause(): fixed-priority interrupt selection (MEI > MSI > MTI)
package trap_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  // mcause values: interrupt bit (31) set, exception code in the low bits.
  localparam logic [XLEN-1:0] CAUSE_MSI = 32'h8000_0003;
  localparam logic [XLEN-1:0] CAUSE_MTI = 32'h8000_0007;
  localparam logic [XLEN-1:0] CAUSE_MEI = 32'h8000_000B;

  // Bit positions inside the 3-bit {meip,mtip,msip} / {meie,mtie,msie} vectors.
  localparam int unsigned IRQ_W   = 3;
  localparam int unsigned IRQ_MSI = 0;
  localparam int unsigned IRQ_MTI = 1;
  localparam int unsigned IRQ_MEI = 2;

  // mepc must be 4-byte aligned; the saved PC has its two low bits cleared.
  localparam logic [XLEN-1:0] TRAP_PC_MASK = 32'hFFFF_FFFC;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRAP   = 2'd1,
    ST_REDIR  = 2'd2,
    ST_MRET_R = 2'd3
  } trap_state_e;

  // Winner of the boundary arbitration.
  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_EXC  = 2'd1,
    EV_MRET = 2'd2,
    EV_INT  = 2'd3
  } trap_event_e;

  // Highest-priority enabled interrupt cause; zero when nothing is pending.
  function automatic logic [XLEN-1:0] irq_cause(input logic [IRQ_W-1:0] pend);
    if (pend[IRQ_MEI]) begin
      return CAUSE_MEI;
    end else if (pend[IRQ_MSI]) begin
      return CAUSE_MSI;
    end else if (pend[IRQ_MTI]) begin
      return CAUSE_MTI;
    end
    return '0;
  endfunction

endpackage

// File: rtl/trap_ctrl_irq_sync.sv
// Single-bit multi-flop synchroniser for a level-sensitive interrupt line.
// Ports:
//   clk_i  in  core clock
//   rst_i  in  synchronous active-high reset (clears every stage)
//   d_i    in  asynchronous level input
//   q_o    out synchronised level, STAGES cycles behind d_i
module trap_ctrl_irq_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift toward the MSB; the MSB is the settled output.
  assign sync_d = {sync_q[STAGES-2:0], d_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/trap_ctrl.sv
// Trap/interrupt sequencer sitting between the EX stage and the CSR file.
// At an EX instruction boundary it picks the highest-priority event
// (exception > MRET > MEI > MSI > MTI), kills the EX instruction for
// traps, pulses trap entry to the CSR file, then flushes the pipe and
// redirects fetch. It also synchronises the interrupt lines and exports
// them as mip for CSR reads.
//
// Handshake: there is no ready on either side. trap_valid and
// redirect_valid are single-cycle pulses that the CSR file and fetch unit
// must consume in the cycle they are high; trap_pc/trap_cause and
// redirect_pc are meaningful only while the matching valid is high and are
// zero otherwise. busy stays high for every non-IDLE cycle so the front
// end holds.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   ex_inst_valid         EX holds a real instruction
//   ex_stall              EX stalled, no boundary this cycle
//   ex_pc                 PC of the EX instruction
//   ex_exc_valid/_cause   synchronous exception from EX and its mcause
//   ex_mret               EX instruction is MRET
//   irq_soft/timer/ext    level interrupt lines (async unless IRQ_SYNC=0)
//   csr_mstatus_mie       global interrupt enable
//   csr_mie               {meie,mtie,msie}
//   csr_trap_vector       mtvec base
//   csr_mepc              current mepc (MRET target)
//   ex_kill               kill the EX instruction (combinational, accept cycle)
//   trap_valid/pc/cause   trap-entry pulse to the CSR file
//   flush                 flush IF/ID/EX
//   redirect_valid/pc     fetch redirect
//   busy                  sequencer not IDLE
//   mip                   synchronised {meip,mtip,msip}
//   dbg_state             current sequencer state
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          IRQ_SYNC    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_inst_valid,
  input  logic              ex_stall,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic              ex_exc_valid,
  input  logic [XLEN-1:0]   ex_exc_cause,
  input  logic              ex_mret,
  input  logic              irq_soft,
  input  logic              irq_timer,
  input  logic              irq_ext,
  input  logic              csr_mstatus_mie,
  input  logic [IRQ_W-1:0]  csr_mie,
  input  logic [XLEN-1:0]   csr_trap_vector,
  input  logic [XLEN-1:0]   csr_mepc,
  output logic              ex_kill,
  output logic              trap_valid,
  output logic [XLEN-1:0]   trap_pc,
  output logic [XLEN-1:0]   trap_cause,
  output logic              flush,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              busy,
  output logic [IRQ_W-1:0]  mip,
  output trap_state_e       dbg_state
);

  // ---------------------------------------------------------------------
  // Interrupt line synchronisation
  // ---------------------------------------------------------------------
  logic [IRQ_W-1:0] irq_raw;
  logic [IRQ_W-1:0] mip_w;

  assign irq_raw = {irq_ext, irq_timer, irq_soft};

  if (IRQ_SYNC) begin : g_sync
    for (genvar i = 0; i < IRQ_W; i++) begin : g_line
      trap_ctrl_irq_sync #(
        .STAGES (SYNC_STAGES)
      ) u_sync (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (irq_raw[i]),
        .q_o   (mip_w[i])
      );
    end
  end else begin : g_bypass
    assign mip_w = irq_raw;
  end

  assign mip = mip_w;

  // ---------------------------------------------------------------------
  // State and capture registers
  // ---------------------------------------------------------------------
  trap_state_e      state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  cause_q, cause_d;

  assign dbg_state = state_q;

  // ---------------------------------------------------------------------
  // Boundary arbiter
  // ---------------------------------------------------------------------
  logic             boundary;
  logic [IRQ_W-1:0] int_pend;
  trap_event_e      ev;
  logic [XLEN-1:0]  ev_cause;

  // Decisions are only taken in IDLE on a real, unstalled instruction, so a
  // bubble or a stall simply defers everything to a later cycle.
  assign boundary = (state_q == ST_IDLE) && ex_inst_valid && !ex_stall;
  assign int_pend = mip_w & csr_mie & {IRQ_W{csr_mstatus_mie}};

  always_comb begin
    ev       = EV_NONE;
    ev_cause = '0;
    if (boundary) begin
      if (ex_exc_valid) begin
        ev       = EV_EXC;
        ev_cause = ex_exc_cause;
      end else if (ex_mret) begin
        ev       = EV_MRET;
      end else if (|int_pend) begin
        ev       = EV_INT;
        ev_cause = irq_cause(int_pend);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Sequencer: next state, capture and outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    cause_d        = cause_q;
    ex_kill        = 1'b0;
    trap_valid     = 1'b0;
    trap_pc        = '0;
    trap_cause     = '0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    busy           = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        unique case (ev)
          EV_EXC, EV_INT: begin
            ex_kill = 1'b1;
            pc_d    = ex_pc;
            cause_d = ev_cause;
            state_d = ST_TRAP;
          end
          // MRET must still retire into the CSR file, so it is not killed
          // and nothing is captured.
          EV_MRET: begin
            state_d = ST_MRET_R;
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end

      ST_TRAP: begin
        trap_valid = 1'b1;
        trap_pc    = pc_q & TRAP_PC_MASK;
        trap_cause = cause_q;
        flush      = 1'b1;
        busy       = 1'b1;
        state_d    = ST_REDIR;
      end

      ST_REDIR: begin
        redirect_valid = 1'b1;
        redirect_pc    = csr_trap_vector;
        flush          = 1'b1;
        busy           = 1'b1;
        state_d        = ST_IDLE;
      end

      ST_MRET_R: begin
        redirect_valid = 1'b1;
        redirect_pc    = csr_mepc;
        flush          = 1'b1;
        busy           = 1'b1;
        state_d        = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A reset cycle drives nothing: a sequence interrupted by reset never
    // shows a partial trap entry or redirect.
    if (rst) begin
      ex_kill        = 1'b0;
      trap_valid     = 1'b0;
      trap_pc        = '0;
      trap_cause     = '0;
      flush          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      busy           = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
    end
  end

endmodule
